// File: rtl/alu_issue_queue_if.sv
// Command/issue bundle between an upstream command source and the ALU issue queue.
interface alu_issue_queue_if #(
    parameter int W  = 16,
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          issue_en;
    logic          flush;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1;
    logic [W-1:0]  alu_input2;
    logic [AW:0]   level;
    logic [15:0]   issue_count;
    logic          err_illegal;
    logic          err_div0;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, issue_en, flush,
        input  cmd_ready, alu_opcode, alu_input1, alu_input2, level, issue_count,
               err_illegal, err_div0
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, issue_en, flush,
        output cmd_ready, alu_opcode, alu_input1, alu_input2, level, issue_count,
               err_illegal, err_div0
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding the accumulator ALU: screens bad commands at push,
// issues one entry per cycle while running, NOOP when idle/paused, RESET on flush.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | queue empty, nothing to issue
// S_RUN   | popping one entry per edge
// S_PAUSE | issue_en low (or just filled while low); queue held
// S_FLUSH | queue emptied; RESET driven on the entry edge
module alu_issue_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic              clk,
    input logic              clear,
    alu_issue_queue_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_FLUSH} state_t;

    localparam logic [3:0]  OP_NOOP  = 4'b0000;
    localparam logic [3:0]  OP_DIV   = 4'b0100;
    localparam logic [3:0]  OP_RESET = 4'b1111;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [3:0]      op_mem_q [DEPTH];
    logic [3:0]      op_mem_d [DEPTH];
    logic [W-1:0]    a_mem_q  [DEPTH];
    logic [W-1:0]    a_mem_d  [DEPTH];
    logic [W-1:0]    b_mem_q  [DEPTH];
    logic [W-1:0]    b_mem_d  [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [3:0]      alu_opcode_q, alu_opcode_d;
    logic [W-1:0]    alu_input1_q, alu_input1_d;
    logic [W-1:0]    alu_input2_q, alu_input2_d;
    logic [15:0]     issue_count_q, issue_count_d;
    logic            err_illegal_q, err_illegal_d;
    logic            err_div0_q, err_div0_d;

    logic            cmd_ready;
    logic            push;
    logic            pop;
    logic            is_illegal;
    logic            is_div0;

    // Handshake, screening and pop decision for this cycle.
    always_comb begin
        // A pop in the same cycle is deliberately ignored so a full queue never accepts.
        cmd_ready  = (level_q != LVL_FULL) && !bus.flush;
        push       = bus.cmd_valid && cmd_ready;
        pop        = (state_q == S_RUN) && (level_q != '0) && !bus.flush;
        is_illegal = (bus.cmd_op >= 4'b1001) && (bus.cmd_op <= 4'b1110);
        is_div0    = (bus.cmd_op == OP_DIV) && (bus.cmd_b == '0);
    end

    // Next-state computation for queue storage, issue registers, counters and FSM.
    always_comb begin
        state_d       = state_q;
        op_mem_d      = op_mem_q;
        a_mem_d       = a_mem_q;
        b_mem_d       = b_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        alu_opcode_d  = OP_NOOP;
        alu_input1_d  = '0;
        alu_input2_d  = '0;
        issue_count_d = issue_count_q;
        err_illegal_d = err_illegal_q;
        err_div0_d    = err_div0_q;

        if (bus.flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            alu_opcode_d = OP_RESET;
            state_d      = S_FLUSH;
        end else begin
            if (push) begin
                if (is_illegal || is_div0) begin
                    op_mem_d[wr_ptr_q] = OP_NOOP;
                    a_mem_d[wr_ptr_q]  = '0;
                    b_mem_d[wr_ptr_q]  = '0;
                end else begin
                    op_mem_d[wr_ptr_q] = bus.cmd_op;
                    a_mem_d[wr_ptr_q]  = bus.cmd_a;
                    b_mem_d[wr_ptr_q]  = bus.cmd_b;
                end
                wr_ptr_d      = wr_ptr_q + AW'(1);
                err_illegal_d = err_illegal_q | is_illegal;
                err_div0_d    = err_div0_q | is_div0;
            end
            if (pop) begin
                alu_opcode_d = op_mem_q[rd_ptr_q];
                alu_input1_d = a_mem_q[rd_ptr_q];
                alu_input2_d = b_mem_q[rd_ptr_q];
                rd_ptr_d     = rd_ptr_q + AW'(1);
                if (op_mem_q[rd_ptr_q] != OP_NOOP) begin
                    issue_count_d = issue_count_q + 16'd1;
                end
            end
            level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            // Transitions look at the post-edge occupancy.
            case (state_q)
                S_IDLE: begin
                    if (level_d != '0) begin
                        state_d = bus.issue_en ? S_RUN : S_PAUSE;
                    end
                end
                S_RUN: begin
                    if (!bus.issue_en) begin
                        state_d = S_PAUSE;
                    end else if (level_d == '0) begin
                        state_d = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    if (bus.issue_en) begin
                        state_d = (level_d != '0) ? S_RUN : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // All state registers; clear forces everything to its idle value.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_q[i] <= '0;
                a_mem_q[i]  <= '0;
                b_mem_q[i]  <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            alu_opcode_q  <= OP_NOOP;
            alu_input1_q  <= '0;
            alu_input2_q  <= '0;
            issue_count_q <= '0;
            err_illegal_q <= 1'b0;
            err_div0_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_mem_q      <= op_mem_d;
            a_mem_q       <= a_mem_d;
            b_mem_q       <= b_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_input1_q  <= alu_input1_d;
            alu_input2_q  <= alu_input2_d;
            issue_count_q <= issue_count_d;
            err_illegal_q <= err_illegal_d;
            err_div0_q    <= err_div0_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_input1  = alu_input1_q;
    assign bus.alu_input2  = alu_input2_q;
    assign bus.level       = level_q;
    assign bus.issue_count = issue_count_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_div0    = err_div0_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_alu_issue_queue;
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } entry_t;

    logic clk;
    logic clear;
    int   n_cmp;
    int   n_bad;

    alu_issue_queue_if #(.W(16), .AW(2)) bus ();

    alu_issue_queue #(.W(16), .DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents, whether popping is enabled this cycle, expected outputs.
    entry_t      mq[$];
    bit          m_run;
    bit          m_flush_prev;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b, m_cnt;
    bit          m_ill, m_d0;
    bit          last_accept;

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_flush_prev = 0;
        m_op = 0; m_a = 0; m_b = 0; m_cnt = 0;
        m_ill = 0; m_d0 = 0;
    endtask

    // One clock: expected ready check, model step, then full output check after the edge.
    // Called with inputs already set, between negedge and posedge.
    task automatic tick();
        bit     exp_ready, acc, pop;
        entry_t e;
        #1;
        exp_ready = (mq.size() < 4) && !bus.flush;
        n_cmp++;
        if (bus.cmd_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL cmd_ready: got %b want %b at %0t", bus.cmd_ready, exp_ready, $time);
        end
        acc = bus.cmd_valid && exp_ready;
        pop = m_run && mq.size() > 0 && !bus.flush;
        if (bus.flush) begin
            mq.delete();
            m_op = 4'hF; m_a = 0; m_b = 0;
        end else begin
            if (pop) begin
                e = mq.pop_front();
                m_op = e.op; m_a = e.a; m_b = e.b;
                if (e.op != 0) m_cnt++;
            end else begin
                m_op = 0; m_a = 0; m_b = 0;
            end
            if (acc) begin
                if (bus.cmd_op >= 9 && bus.cmd_op <= 14) begin
                    m_ill = 1;
                    mq.push_back('{op: 4'd0, a: 16'd0, b: 16'd0});
                end else if (bus.cmd_op == 4 && bus.cmd_b == 0) begin
                    m_d0 = 1;
                    mq.push_back('{op: 4'd0, a: 16'd0, b: 16'd0});
                end else begin
                    mq.push_back('{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b});
                end
            end
        end
        m_run = !bus.flush && !m_flush_prev && bus.issue_en && mq.size() > 0;
        m_flush_prev = bus.flush;
        last_accept = acc;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.alu_opcode !== m_op || bus.alu_input1 !== m_a || bus.alu_input2 !== m_b) begin
            n_bad++;
            $display("FAIL alu_out: got %h/%h/%h want %h/%h/%h at %0t", bus.alu_opcode,
                     bus.alu_input1, bus.alu_input2, m_op, m_a, m_b, $time);
        end
        n_cmp++;
        if (bus.level !== 3'(mq.size()) || bus.issue_count !== m_cnt) begin
            n_bad++;
            $display("FAIL level_count: got %0d/%0d want %0d/%0d at %0t", bus.level,
                     bus.issue_count, mq.size(), m_cnt, $time);
        end
        n_cmp++;
        if (bus.err_illegal !== m_ill || bus.err_div0 !== m_d0) begin
            n_bad++;
            $display("FAIL err_flags: got %b%b want %b%b at %0t", bus.err_illegal,
                     bus.err_div0, m_ill, m_d0, $time);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    endtask

    task automatic idle_ticks(input int n);
        drive(0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.issue_en = 0;
        drive(1, 4'h1, 16'd5, 16'd6); tick();
        drive(1, 4'hA, 16'd7, 16'd8); tick();
        drive(1, 4'h2, 16'd9, 16'd1); tick();
        drive(1, 4'h3, 16'd2, 16'd2);
        n_cmp++;
        if (bus.level !== 3'd3 || bus.err_illegal !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre: level %0d err_ill %b want 3 1", bus.level, bus.err_illegal);
        end
        #2 clear = 1'b1;
        #1;
        n_cmp++;
        if (bus.alu_opcode !== 0 || bus.alu_input1 !== 0 || bus.alu_input2 !== 0 ||
            bus.level !== 0 || bus.issue_count !== 0 || bus.err_illegal !== 0 ||
            bus.err_div0 !== 0) begin
            n_bad++;
            $display("FAIL reset_async: op %h l %0d cnt %0d errs %b%b want all zero",
                     bus.alu_opcode, bus.level, bus.issue_count, bus.err_illegal, bus.err_div0);
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        bus.issue_en = 1;
        drive(1, 4'h1, 16'd1, 16'd1); tick();
        drive(1, 4'h2, 16'd3, 16'd1); tick();
        n_cmp++;
        if (bus.alu_opcode !== 4'h1 || bus.alu_input1 !== 16'd1) begin
            n_bad++;
            $display("FAIL stream_add: got %h/%0d want 1/1", bus.alu_opcode, bus.alu_input1);
        end
        drive(1, 4'h3, 16'd2, 16'd2); tick();
        idle_ticks(3);
        n_cmp++;
        if (bus.issue_count !== 16'd3 || bus.alu_opcode !== 4'h0) begin
            n_bad++;
            $display("FAIL stream_count: got %0d/%h want 3/0", bus.issue_count, bus.alu_opcode);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        bus.issue_en = 0;
        sent = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'(1 + sent % 3), 16'(10 + sent), 16'(20 + sent));
            tick();
            if (last_accept && sent < 4) sent++;
        end
        n_cmp++;
        if (bus.level !== 3'd4 || bus.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full: level %0d ready %b want 4 0", bus.level, bus.cmd_ready);
        end
        bus.issue_en = 1;
        for (int i = 0; i < 12 && !last_accept; i++) tick();
        n_cmp++;
        if (!last_accept) begin
            n_bad++;
            $display("FAIL fifth_accept: got 0 want 1");
        end
        idle_ticks(6);
        n_cmp++;
        if (bus.level !== 0 || bus.issue_count !== m_cnt) begin
            n_bad++;
            $display("FAIL drain: level %0d cnt %0d want 0 %0d", bus.level, bus.issue_count, m_cnt);
        end
    endtask

    task automatic test_screening();
        do_clear();
        bus.issue_en = 1;
        drive(1, 4'h4, 16'd8, 16'd0); tick();
        drive(1, 4'hA, 16'd5, 16'd5); tick();
        drive(1, 4'h4, 16'd8, 16'd2); tick();
        idle_ticks(3);
        n_cmp++;
        if (bus.err_div0 !== 1'b1 || bus.err_illegal !== 1'b1 || bus.issue_count !== 16'd1) begin
            n_bad++;
            $display("FAIL screen: d0 %b ill %b cnt %0d want 1 1 1", bus.err_div0,
                     bus.err_illegal, bus.issue_count);
        end
    endtask

    task automatic test_flush();
        bus.issue_en = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'h5, 16'(i), 16'(i + 1)); tick();
        end
        bus.flush = 1;
        drive(1, 4'h6, 16'hAAAA, 16'h5555);
        tick();
        n_cmp++;
        if (bus.alu_opcode !== 4'hF || bus.alu_input1 !== 0 || bus.level !== 0) begin
            n_bad++;
            $display("FAIL flush: op %h in1 %h level %0d want f 0 0", bus.alu_opcode,
                     bus.alu_input1, bus.level);
        end
        bus.flush = 0;
        bus.issue_en = 1;
        idle_ticks(1);
        n_cmp++;
        if (bus.alu_opcode !== 4'h0 || bus.level !== 0) begin
            n_bad++;
            $display("FAIL post_flush: op %h level %0d want 0 0", bus.alu_opcode, bus.level);
        end
        idle_ticks(2);
    endtask

    task automatic test_wrap();
        int pushed;
        pushed = 0;
        for (int c = 0; c < 60 && pushed < 10; c++) begin
            bus.issue_en = c[0];
            drive(1, 4'($urandom_range(1, 8)), 16'($urandom), 16'($urandom_range(1, 65535)));
            tick();
            if (last_accept) pushed++;
            n_cmp++;
            if (bus.level > 3'd4) begin
                n_bad++;
                $display("FAIL wrap_level: got %0d want <=4", bus.level);
            end
        end
        bus.issue_en = 1;
        idle_ticks(8);
        n_cmp++;
        if (pushed != 10 || bus.level !== 0) begin
            n_bad++;
            $display("FAIL wrap_drain: pushed %0d level %0d want 10 0", pushed, bus.level);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.issue_en = ($urandom_range(0, 3) != 0);
            bus.flush    = ($urandom_range(0, 29) == 0);
            drive($urandom_range(0, 2) != 0, 4'($urandom),
                  16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
            tick();
        end
        bus.flush = 0;
        idle_ticks(6);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_accept = 0;
        clear = 1'b1;
        bus.issue_en = 0;
        bus.flush = 0;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_screening();
        test_flush();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
